x_sequencer_engine: RTL and testbench

X_SEQUENCER_ENGINE -- requirements
Module: x_sequencer_engine

---
 rtl/x_sequencer_engine_pkg.sv | 21 ++
 rtl/x_sequencer_engine_ram.sv | 23 ++
 rtl/x_sequencer_engine.sv | 161 ++++++++++++++++
 tb/tb_x_sequencer_engine.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/x_sequencer_engine_pkg.sv
// Shared types and command encodings for the x_sequencer_engine program sequencer.
// Optional LOOP command is enabled by the X_SEQUENCER_ENGINE_LOOP_EN macro.
package x_sequencer_engine_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_DELAY
  } state_t;

  localparam int CMD_DAT  = 0;
  localparam int CMD_DEL  = 1;
  localparam int CMD_END  = 2;
  localparam int CMD_JMP  = 3;
  localparam int CMD_LOOP = 4;

  // LOOP count field width; it sits directly above the target address in the payload.
  localparam int LOOP_W = 16;

endpackage

// File: rtl/x_sequencer_engine_ram.sv
// Single-port-write, registered-read program RAM for the sequencer.
// Each entry holds {payload, cmd}; the read word appears one clock after the address.
module x_sequencer_engine_ram #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 512
) (
  input  logic                     clk,
  input  logic                     wen,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset so it maps onto block RAM and survives a core reset.
  always_ff @(posedge clk) begin
    if (wen) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/x_sequencer_engine.sv
// Program sequencer: fetches {payload, cmd} words from internal RAM and drives o_data.
// Define X_SEQUENCER_ENGINE_LOOP_EN to enable the single-level LOOP command.
module x_sequencer_engine
  import x_sequencer_engine_pkg::*;
#(
  parameter int DATA_W  = 36,
  parameter int ADDR_W  = 9,
  parameter int DELAY_W = 17,
  parameter int CMD_W   = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_stop,
  output logic              o_busy,
  output logic              o_done,
  input  logic              i_wen,
  input  logic [CMD_W-1:0]  i_wcmd,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_waddr,
  output logic [DATA_W-1:0] o_data,
  output logic [ADDR_W-1:0] o_pc
);

  localparam int RAM_W = DATA_W + CMD_W;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d, pc_inc, jump_tgt;
  logic [DELAY_W-1:0] dly_q, dly_d, dly_n;
  logic [DATA_W-1:0]  data_q, data_d, payload;
  logic               done_q, done_d;
  logic [CMD_W-1:0]   cmd;
  logic [RAM_W-1:0]   rd_word;

  x_sequencer_engine_ram #(
    .WIDTH (RAM_W),
    .DEPTH (2**ADDR_W)
  ) u_ram (
    .clk   (i_clk),
    .wen   (i_wen && (state_q == S_IDLE)),
    .waddr (i_waddr),
    .wdata ({i_wdata, i_wcmd}),
    .raddr (pc_q),
    .rdata (rd_word)
  );

  assign payload  = rd_word[RAM_W-1:CMD_W];
  assign cmd      = rd_word[CMD_W-1:0];
  assign dly_n    = payload[DELAY_W-1:0];
  assign jump_tgt = payload[ADDR_W-1:0];
  assign pc_inc   = pc_q + 1'b1;

`ifdef X_SEQUENCER_ENGINE_LOOP_EN
  logic [LOOP_W-1:0] loop_q, loop_d, loop_cnt;
  assign loop_cnt = payload[ADDR_W+LOOP_W-1:ADDR_W];
`endif

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    dly_d   = dly_q;
    data_d  = data_q;
    done_d  = 1'b0;
`ifdef X_SEQUENCER_ENGINE_LOOP_EN
    loop_d  = loop_q;
`endif
    if (i_stop) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            state_d = S_FETCH;
            pc_d    = '0;
`ifdef X_SEQUENCER_ENGINE_LOOP_EN
            loop_d  = '0;
`endif
          end
        end
        S_FETCH: state_d = S_EXEC;
        S_EXEC: begin
          // Sequential advance is the fallback; unknown commands therefore act as NOP.
          state_d = S_FETCH;
          pc_d    = pc_inc;
          case (cmd)
            CMD_W'(CMD_DAT): data_d = payload;
            CMD_W'(CMD_DEL): begin
              if (dly_n != '0) begin
                dly_d   = dly_n - 1'b1;
                state_d = S_DELAY;
                pc_d    = pc_q;
              end
            end
            CMD_W'(CMD_END): begin
              state_d = S_IDLE;
              done_d  = 1'b1;
              pc_d    = pc_q;
            end
            CMD_W'(CMD_JMP): pc_d = jump_tgt;
`ifdef X_SEQUENCER_ENGINE_LOOP_EN
            CMD_W'(CMD_LOOP): begin
              if (loop_cnt != '0) begin
                if (loop_q == '0) begin
                  loop_d = loop_cnt;
                  pc_d   = jump_tgt;
                end else if (loop_q > LOOP_W'(1)) begin
                  loop_d = loop_q - 1'b1;
                  pc_d   = jump_tgt;
                end else begin
                  loop_d = '0;
                end
              end
            end
`endif
            default: ;
          endcase
        end
        S_DELAY: begin
          if (dly_q == '0) begin
            state_d = S_FETCH;
            pc_d    = pc_inc;
          end else begin
            dly_d = dly_q - 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      dly_q   <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      dly_q   <= dly_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

`ifdef X_SEQUENCER_ENGINE_LOOP_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) loop_q <= '0;
    else       loop_q <= loop_d;
  end
`endif

  assign o_busy = (state_q != S_IDLE);
  assign o_done = done_q;
  assign o_data = data_q;
  assign o_pc   = pc_q;

endmodule

// File: tb/tb_x_sequencer_engine.sv
// Self-checking bench for x_sequencer_engine: table of small programs plus directed corner cases.
// Expectations for LOOP follow the X_SEQUENCER_ENGINE_LOOP_EN macro.
module tb_x_sequencer_engine;
  import x_sequencer_engine_pkg::*;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1, i_start = 1'b0, i_stop = 1'b0, i_wen = 1'b0;
  logic [3:0]  i_wcmd = '0;
  logic [35:0] i_wdata = '0;
  logic [8:0]  i_waddr = '0;
  logic        o_busy, o_done;
  logic [35:0] o_data;
  logic [8:0]  o_pc;

  x_sequencer_engine dut (
    .i_clk   (clk),
    .i_rst   (i_rst),
    .i_start (i_start),
    .i_stop  (i_stop),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .i_wen   (i_wen),
    .i_wcmd  (i_wcmd),
    .i_wdata (i_wdata),
    .i_waddr (i_waddr),
    .o_data  (o_data),
    .o_pc    (o_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [35:0] data;
  } exp_t;

  typedef struct {
    logic [3:0]  cmd;
    logic [35:0] pay;
    logic [35:0] a;
    logic [35:0] b;
    int          b_cyc;
    int          done_cyc;
  } vec_t;

  exp_t        sb_q[$];
  vec_t        vecs[7];
  logic [35:0] model_data = '0;
  int          n_cmp = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [8:0] a, input int c, input logic [35:0] p);
    i_wen = 1'b1; i_waddr = a; i_wcmd = 4'(c); i_wdata = p;
    tick();
    i_wen = 1'b0;
  endtask

  // Starts the program and checks o_data against the scoreboard every cycle, plus done/busy timing.
  task automatic run_prog(input int done_cyc, input int pc01_exp, input bit inject);
    int         pc01;
    logic [8:0] prev_pc;
    exp_t       e;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    prev_pc = 9'd0;
    pc01    = 0;
    for (int k = 1; k <= done_cyc + 1; k++) begin
      tick();
      if (prev_pc == 9'd0 && o_pc == 9'd1) pc01++;
      prev_pc = o_pc;
      if (sb_q.size() > 0 && sb_q[0].cyc == k) begin
        e = sb_q.pop_front();
        model_data = e.data;
      end
      check($sformatf("data_k%0d", k), o_data, model_data);
      check($sformatf("done_k%0d", k), o_done, k == done_cyc);
      check($sformatf("busy_k%0d", k), o_busy, k < done_cyc);
      if (inject) begin
        if (k == 1) begin
          i_wen = 1'b1; i_waddr = 9'd1; i_wcmd = 4'(CMD_DAT); i_wdata = 36'hEE;
        end
        if (k == 2) i_wen = 1'b0;
        if (k == 3) i_start = 1'b1;
        if (k == 4) i_start = 1'b0;
      end
    end
    if (sb_q.size() != 0) begin
      check("sb_leftover", sb_q.size(), 0);
      sb_q.delete();
    end
    check("dat_count", pc01, pc01_exp);
  endtask

  function automatic exp_t mk(input int c, input logic [35:0] d);
    exp_t e;
    e.cyc = c; e.data = d;
    return e;
  endfunction

  initial begin
    vecs[0] = '{4'(CMD_DEL),  36'd5,              36'h111, 36'h222, 11, 13};
    vecs[1] = '{4'(CMD_DEL),  36'd0,              36'h333, 36'h444,  6,  8};
    vecs[2] = '{4'(CMD_DEL),  36'd1,              36'h555, 36'h666,  7,  9};
    vecs[3] = '{4'(CMD_DEL),  36'h20003,          36'h777, 36'h888,  9, 11};
    vecs[4] = '{4'd7,         36'hFFF,            36'h999, 36'hAAA,  6,  8};
    vecs[5] = '{4'(CMD_JMP),  36'd2,              36'hBBB, 36'hCCC,  6,  8};
    vecs[6] = '{4'(CMD_LOOP), 36'd0,              36'hDDD, 36'h123,  6,  8};

    // Reset state
    tick(); tick();
    i_rst = 1'b0;
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_data", o_data, 0);
    check("rst_pc",   o_pc,   0);

    // Basic DAT/DAT/END with ignored write and start while busy
    wr(9'd0, CMD_DAT, 36'hA);
    wr(9'd1, CMD_DAT, 36'hB);
    wr(9'd2, CMD_END, 36'h0);
    sb_q.push_back(mk(2, 36'hA));
    sb_q.push_back(mk(4, 36'hB));
    run_prog(6, 1, 1'b1);

    // Table: DAT a, <mid>, DAT b, END
    for (int i = 0; i < 7; i++) begin
      wr(9'd0, CMD_DAT, vecs[i].a);
      wr(9'd1, int'(vecs[i].cmd), vecs[i].pay);
      wr(9'd2, CMD_DAT, vecs[i].b);
      wr(9'd3, CMD_END, 36'h0);
      sb_q.push_back(mk(2, vecs[i].a));
      sb_q.push_back(mk(vecs[i].b_cyc, vecs[i].b));
      run_prog(vecs[i].done_cyc, 1, 1'b0);
    end

    // JMP to last address, then PC wraps to 0
    wr(9'd0,   CMD_JMP, 36'h1FF);
    wr(9'h1FF, CMD_DAT, 36'h5A5A);
    i_start = 1'b1; tick(); i_start = 1'b0;
    tick(); check("jmp_pc_k1", o_pc, 9'd0);
    tick(); check("jmp_pc_k2", o_pc, 9'h1FF);
    tick(); check("jmp_pc_k3", o_pc, 9'h1FF);
    tick(); check("wrap_pc_k4", o_pc, 9'd0);
    check("wrap_data_k4", o_data, 36'h5A5A);
    i_stop = 1'b1; tick(); i_stop = 1'b0;
    check("jmp_stop_busy", o_busy, 0);
    check("jmp_stop_done", o_done, 0);
    model_data = 36'h5A5A;

    // Stop during a long DELAY
    wr(9'd0, CMD_DAT, 36'h77);
    wr(9'd1, CMD_DEL, 36'd200);
    wr(9'd2, CMD_DAT, 36'h88);
    wr(9'd3, CMD_END, 36'h0);
    i_start = 1'b1; tick(); i_start = 1'b0;
    for (int k = 1; k <= 104; k++) tick();
    check("dly_busy_k104", o_busy, 1);
    check("dly_data_k104", o_data, 36'h77);
    i_stop = 1'b1; tick(); i_stop = 1'b0;
    check("stop_busy", o_busy, 0);
    check("stop_data", o_data, 36'h77);
    for (int k = 0; k < 3; k++) begin
      check("stop_no_done", o_done, 0);
      tick();
    end
    model_data = 36'h77;
    wr(9'd0, CMD_DAT, 36'h99);
    wr(9'd1, CMD_END, 36'h0);
    sb_q.push_back(mk(2, 36'h99));
    run_prog(4, 1, 1'b0);

    // Reset mid-run, then identical restart
    wr(9'd0, CMD_DAT, 36'hA);
    wr(9'd1, CMD_DAT, 36'hB);
    wr(9'd2, CMD_END, 36'h0);
    i_start = 1'b1; tick(); i_start = 1'b0;
    tick(); tick(); tick();
    i_rst = 1'b1; tick(); i_rst = 1'b0;
    check("mrst_data", o_data, 0);
    check("mrst_pc",   o_pc,   0);
    check("mrst_busy", o_busy, 0);
    check("mrst_done", o_done, 0);
    model_data = '0;
    sb_q.push_back(mk(2, 36'hA));
    sb_q.push_back(mk(4, 36'hB));
    run_prog(6, 1, 1'b0);

    // LOOP target=0 count=3
    wr(9'd0, CMD_DAT, 36'h1);
    wr(9'd1, CMD_LOOP, 36'd3 << 9);
    wr(9'd2, CMD_END, 36'h0);
    sb_q.push_back(mk(2, 36'h1));
`ifdef X_SEQUENCER_ENGINE_LOOP_EN
    run_prog(18, 4, 1'b0);
`else
    run_prog(6, 1, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
